// File: rtl/bounded_grant_arbiter.sv
// -----------------------------------------------------------------------------
// bounded_grant_arbiter
//
// Round-robin arbiter that hands a shared bounded-counter resource to one of
// N_REQ requesters at a time. A tenure lasts at most MAX_BEATS cycles. It ends
// early when the owner drops its request or raises its done bit. Every tenure
// is followed by exactly one turnaround (GAP) cycle.
//
// Parameters
//   N_REQ      number of requesters (2..8)
//   MAX_BEATS  maximum tenure length in cycles (1..3)
//   CNT_W      beat counter width, must be able to hold MAX_BEATS
//
// Ports
//   clk_i          single clock, rising edge
//   resetn_i       synchronous active-low reset
//   req_i          level request per requester
//   done_i         early release, only the current owner's bit is honoured
//   gnt_o          one-hot grant (registered)
//   gnt_valid_o    OR of gnt_o (registered)
//   gnt_id_o       index of the current or last owner (registered)
//   beat_cnt_o     beat number of the current tenure, 1..MAX_BEATS, 0 when idle
//   expired_o      one-cycle pulse in the GAP cycle after a tenure that ended by
//                  reaching MAX_BEATS
// -----------------------------------------------------------------------------
module bounded_grant_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BEATS = 3,
  parameter int CNT_W     = 2,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] done_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             gnt_valid_o,
  output logic [ID_W-1:0]  gnt_id_o,
  output logic [CNT_W-1:0] beat_cnt_o,
  output logic             expired_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Round-robin search: the first set request strictly after `lst`, wrapping
  // around. The previous owner is therefore examined last. Returns
  // {found, index}.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [ID_W-1:0]  lst);
    logic            found;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((int'(lst) + i) % N_REQ);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             expired_q, expired_d;
  logic [ID_W-1:0]  last_q, last_d;

  logic [ID_W:0]    pick_s;
  logic             win_found_s;
  logic [ID_W-1:0]  win_idx_s;
  logic             owner_rel_s;
  logic             at_max_s;

  assign pick_s      = rr_pick(req_i, last_q);
  assign win_found_s = pick_s[ID_W];
  assign win_idx_s   = pick_s[ID_W-1:0];

  // Owner-driven release has priority over expiry, so a done in the final
  // beat reports a normal (non-expired) end of tenure.
  assign owner_rel_s = ~req_i[gnt_id_q] | done_i[gnt_id_q];
  assign at_max_s    = (beat_cnt_q == CNT_W'(MAX_BEATS));

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      beat_cnt_q  <= '0;
      expired_q   <= 1'b0;
      last_q      <= ID_W'(N_REQ - 1);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      beat_cnt_q  <= beat_cnt_d;
      expired_q   <= expired_d;
      last_q      <= last_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (win_found_s) begin
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (owner_rel_s || at_max_s) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a safe idle state.
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and of the round-robin pointer.
  always_comb begin
    gnt_d      = '0;
    gnt_id_d   = gnt_id_q;
    beat_cnt_d = '0;
    expired_d  = 1'b0;
    last_d     = last_q;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (win_found_s) begin
          gnt_d      = N_REQ'(1) << win_idx_s;
          gnt_id_d   = win_idx_s;
          beat_cnt_d = CNT_W'(1);
          last_d     = win_idx_s;
        end else begin
          gnt_d      = '0;
          beat_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (owner_rel_s) begin
          gnt_d      = '0;
          beat_cnt_d = '0;
          expired_d  = 1'b0;
        end else if (at_max_s) begin
          gnt_d      = '0;
          beat_cnt_d = '0;
          expired_d  = 1'b1;
        end else begin
          // Below the limit here, so the increment cannot wrap.
          gnt_d      = gnt_q;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        gnt_d      = '0;
        beat_cnt_d = '0;
        expired_d  = 1'b0;
      end
    endcase
    gnt_valid_d = |gnt_d;
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = gnt_valid_q;
  assign gnt_id_o    = gnt_id_q;
  assign beat_cnt_o  = beat_cnt_q;
  assign expired_o   = expired_q;

endmodule

// File: tb/tb_bounded_grant_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for bounded_grant_arbiter. Two instances share the same stimulus:
// the default build (MAX_BEATS=3) and a MAX_BEATS=1 build. A behavioural
// owner/tenure model predicts every output cycle by cycle.
// -----------------------------------------------------------------------------
module tb_bounded_grant_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         resetn;
  logic [N-1:0] req;
  logic [N-1:0] done;

  logic [N-1:0] gnt0, gnt1;
  logic         gv0, gv1;
  logic [1:0]   id0, id1;
  logic [1:0]   bc0;
  logic [0:0]   bc1;
  logic         ex0, ex1;

  int n_cmp  = 0;
  int n_fail = 0;

  bounded_grant_arbiter #(.N_REQ(N), .MAX_BEATS(3), .CNT_W(2)) dut0 (
    .clk_i(clk), .resetn_i(resetn), .req_i(req), .done_i(done),
    .gnt_o(gnt0), .gnt_valid_o(gv0), .gnt_id_o(id0),
    .beat_cnt_o(bc0), .expired_o(ex0)
  );

  bounded_grant_arbiter #(.N_REQ(N), .MAX_BEATS(1), .CNT_W(1)) dut1 (
    .clk_i(clk), .resetn_i(resetn), .req_i(req), .done_i(done),
    .gnt_o(gnt1), .gnt_valid_o(gv1), .gnt_id_o(id1),
    .beat_cnt_o(bc1), .expired_o(ex1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the resource, for how many beats so far,
  // who won last, last reported owner and the expiry flag.
  int m_owner [2];
  int m_beats [2];
  int m_last  [2];
  int m_id    [2];
  int m_exp   [2];
  int m_max   [2];

  task automatic model_step(input int k);
    int w;
    if (!resetn) begin
      m_owner[k] = -1; m_beats[k] = 0; m_id[k] = 0;
      m_last[k] = N - 1; m_exp[k] = 0;
    end else if (m_owner[k] >= 0) begin
      m_exp[k] = 0;
      if (!req[m_owner[k]] || done[m_owner[k]]) begin
        m_owner[k] = -1; m_beats[k] = 0;
      end else if (m_beats[k] == m_max[k]) begin
        m_owner[k] = -1; m_beats[k] = 0; m_exp[k] = 1;
      end else begin
        m_beats[k] = m_beats[k] + 1;
      end
    end else begin
      m_exp[k] = 0;
      w = -1;
      for (int i = 1; i <= N; i++) begin
        if (w < 0 && req[(m_last[k] + i) % N]) w = (m_last[k] + i) % N;
      end
      if (w >= 0) begin
        m_owner[k] = w; m_id[k] = w; m_last[k] = w; m_beats[k] = 1;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_gnt(input int k);
    return (m_owner[k] >= 0) ? (32'd1 << m_owner[k]) : 32'd0;
  endfunction

  // One clock: advance model with the inputs sampled at this edge, then
  // compare both instances just after the edge.
  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("gnt_m3",      {28'd0, gnt0}, exp_gnt(0));
    check("gvalid_m3",   {31'd0, gv0},  (m_owner[0] >= 0) ? 32'd1 : 32'd0);
    check("gnt_id_m3",   {30'd0, id0},  m_id[0]);
    check("beat_m3",     {30'd0, bc0},  m_beats[0]);
    check("expired_m3",  {31'd0, ex0},  m_exp[0]);
    check("onehot_m3",   {31'd0, $onehot0(gnt0)}, 32'd1);
    check("gnt_m1",      {28'd0, gnt1}, exp_gnt(1));
    check("gvalid_m1",   {31'd0, gv1},  (m_owner[1] >= 0) ? 32'd1 : 32'd0);
    check("gnt_id_m1",   {30'd0, id1},  m_id[1]);
    check("beat_m1",     {31'd0, bc1},  m_beats[1]);
    check("expired_m1",  {31'd0, ex1},  m_exp[1]);
  endtask

  initial begin
    m_max[0] = 3; m_max[1] = 1;
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_beats[k] = 0; m_last[k] = N - 1; m_id[k] = 0; m_exp[k] = 0;
    end
    resetn = 1'b0; req = '0; done = '0;

    // Reset state.
    step(); step();
    check("reset_gnt",  {28'd0, gnt0}, 32'd0);
    check("reset_beat", {30'd0, bc0},  32'd0);

    // Single requester held: 3 beats, GAP with expired, then again.
    resetn = 1'b1; req = 4'b0001;
    step();
    check("single_beat1", {30'd0, bc0}, 32'd1);
    step(); step();
    check("single_beat3", {30'd0, bc0}, 32'd3);
    step();
    check("single_gap_expired", {31'd0, ex0}, 32'd1);
    check("single_gap_gnt", {28'd0, gnt0}, 32'd0);
    step();
    check("single_regrant", {28'd0, gnt0}, 32'd1);
    for (int i = 0; i < 4; i++) step();

    // Round robin with everyone requesting.
    req = 4'b0000; step(); step();
    req = 4'b1111;
    for (int i = 0; i < 20; i++) step();

    // Early done in beat 2; non-owner done in beat 1 is ignored.
    req = 4'b0000; done = 4'b0000; step(); step();
    req = 4'b0100; step();
    check("early_owner", {30'd0, id0}, 32'd2);
    done = 4'b0001; step();
    check("nonowner_done_ignored", {30'd0, bc0}, 32'd2);
    done = 4'b0100; step();
    check("early_release_gnt", {28'd0, gnt0}, 32'd0);
    check("early_release_noexp", {31'd0, ex0}, 32'd0);
    done = 4'b0000;

    // Simultaneous done and last beat.
    for (int t = 0; t < 8 && !(m_beats[0] == 3); t++) step();
    check("beat3_reached", {30'd0, bc0}, 32'd3);
    done = 4'b0100; step();
    check("simul_end_noexp", {31'd0, ex0}, 32'd0);
    check("simul_end_gnt", {28'd0, gnt0}, 32'd0);
    done = 4'b0000;

    // Reset in the middle of a grant, then priority restarts at 0.
    req = 4'b0000; step(); step();
    req = 4'b0010; step(); step();
    check("mid_beat2", {30'd0, bc0}, 32'd2);
    resetn = 1'b0; step();
    check("midreset_gnt", {28'd0, gnt0}, 32'd0);
    check("midreset_id", {30'd0, id0}, 32'd0);
    resetn = 1'b1; req = 4'b0011; step();
    check("after_reset_first", {28'd0, gnt0}, 32'd1);

    // Two requesters held: exercises alternating 1-beat tenures on MAX_BEATS=1.
    for (int i = 0; i < 12; i++) step();

    // Randomised traffic with occasional done pulses and resets.
    for (int i = 0; i < 400; i++) begin
      req    = 4'($urandom);
      if ($urandom_range(0, 2) == 0) req = 4'b1111;
      done   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      resetn = ($urandom_range(0, 60) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bounded_grant_arbiter.md
# bounded_grant_arbiter

Round-robin arbiter that shares the bounded counter resource among `N_REQ` requesters. Each grant lasts at most `MAX_BEATS` cycles and never more. An internal beat counter counts up to the limit and stops there. The block sits in front of the counter datapath: it decides who owns it, for how long, and reports when a tenure ends.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `MAX_BEATS`, 3: maximum grant length in cycles (1..3).
- `CNT_W`, 2: beat counter width. It must hold `MAX_BEATS`.

- `clk`, in, 1: single clock. All logic is on its rising edge.
- `resetn`, in, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req`, in, `N_REQ`: level request per requester. It must stay high while the requester wants the resource.
- `done`, in, `N_REQ`: early release. Only the bit of the current owner is honoured.
- `gnt`, out, `N_REQ`: one-hot grant, registered.
- `gnt_valid`, out, 1: OR of `gnt`, registered.
- `gnt_id`, out, clog2(`N_REQ`): index of the current or last owner.
- `beat_cnt`, out, `CNT_W`: beat number of the current tenure. It is 1 in the first grant cycle and 0 when idle.
- `expired`, out, 1: one-cycle pulse. It means the previous tenure ended because it hit `MAX_BEATS`.

## Operation
- The FSM has three states: IDLE, GRANT and GAP. All outputs are registered.
- **IDLE:** `gnt` = 0 and `beat_cnt` = 0. If any `req` bit is high, the winner is chosen and the next state is GRANT.
- **Arbitration:** round-robin. The search starts at index `last`+1 mod `N_REQ` and takes the first set `req` bit.
  - `last` is the previous winner.
  - After reset, `last` = `N_REQ`-1, so requester 0 has priority first.
- **Entering GRANT:** `gnt[w]`=1, `gnt_id`=w, `beat_cnt`=1, `last`=w.
- **GRANT:** an exit condition is evaluated every cycle, in priority order:
  1. `req[gnt_id]`=0 or `done[gnt_id]`=1: next state GAP, `expired` stays 0.
  2. Otherwise, `beat_cnt`==`MAX_BEATS`: next state GAP, `expired`=1 in the GAP cycle.
  3. Otherwise: `beat_cnt` increments.
  - `beat_cnt` never exceeds `MAX_BEATS` and never wraps.
- **GAP:** one mandatory turnaround cycle with `gnt`=0 and `beat_cnt`=0.
  - Arbitration is performed here exactly as in IDLE.
  - Any request leads to GRANT next. No request leads to IDLE.
  - The previous owner is eligible again, but only after all other requesters in round-robin order.
- **Ignored inputs:** `done` bits of non-owners are ignored. `req` changes of non-owners only affect the next arbitration.
- **Reset (`resetn`=0 at an edge):** state becomes IDLE and `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `beat_cnt`=0, `expired`=0, `last`=`N_REQ`-1.
  - Reset is honoured in any state, including mid-grant. `gnt` is low in the cycle after that edge.
  - `resetn`=0 overrides all other inputs.

## Timing
- **Request to grant:** `req` sampled high at edge t in IDLE or GAP gives `gnt` high after edge t (latency 1).
- **Maximum tenure:** exactly `MAX_BEATS` cycles of `gnt` high, then one GAP cycle.
- **Continuous requesters:** the period per requester turn is `MAX_BEATS`+1 cycles.
- **Early release:** `done` or a `req` drop sampled during beat k gives `gnt` low in the next cycle. The tenure is k cycles.
- **Simultaneous end conditions:** `done` and `beat_cnt`==`MAX_BEATS` in the same cycle end the tenure with `expired`=0.
- **`MAX_BEATS`=1:** every tenure is 1 cycle. `expired`=1 after each tenure unless `done` or a `req` drop occurred.
- **`expired`:** high only in the GAP cycle, for exactly one cycle.

## Test plan
- **Reset and single requester:** reset, then `req`=0001 held. Expected: `gnt`=0001 for 3 cycles (`beat_cnt` 1,2,3), then GAP with `expired`=1, then `gnt` again. Period is 4 cycles and `beat_cnt` is never 0 during `gnt`.
- **Round-robin:** `req`=1111 held. Expected grant order 0,1,2,3,0 with `gnt_id` matching, one GAP between tenures, and `gnt` always one-hot or zero.
- **Early done:** `req`=0100 and `done[2]`=1 in beat 2. Expected: `gnt` low in the next cycle, `expired`=0, tenure 2 cycles. Pulsing `done[0]` during the same tenure has no effect.
- **Simultaneous end:** `done[gnt_id]`=1 during beat 3. Expected: tenure ends with `expired`=0.
- **Reset mid-grant:** `req`=0010, `resetn`=0 during beat 2. Expected: all outputs 0 after that edge. After release, `req`=0011 is granted to 0 first.
- **`MAX_BEATS`=1 build:** `req`=0011 held. Expected: alternating 1-cycle grants 0,1,0 separated by GAP cycles, each followed by `expired`=1.
